// File: rtl/test_scoreboard_pkg.sv
// Shared definitions for the test scoreboard: state and fail-cause encodings,
// channel limits and the popcount helper used by the parent.
package test_scoreboard_pkg;

   // Verdict FSM encoding; the numeric values are visible on the state port.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PASS = 2'd2,
      ST_FAIL = 2'd3
   } sb_state_t;

   // Reason reported alongside a FAIL verdict.
   typedef enum logic [1:0] {
      CAUSE_NONE     = 2'd0,
      CAUSE_MISMATCH = 2'd1,
      CAUSE_COUNT    = 2'd2,
      CAUSE_TIMEOUT  = 2'd3
   } fail_cause_t;

   localparam int MAX_CHANNELS = 16;
   localparam int CHAN_W       = 4;

   // Number of set bits in a full-width channel vector.
   function automatic logic [4:0] popcount16(input logic [MAX_CHANNELS-1:0] v);
      logic [4:0] n;
      n = '0;
      for (int i = 0; i < MAX_CHANNELS; i++) begin
         n = n + 5'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/test_scoreboard_lane.sv
// One compare lane: flags a mismatch when any masked bit of expected and
// measured differ. Purely combinational; the parent qualifies it with valid.
module test_scoreboard_lane #(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] expected,
   input  logic [DATA_WIDTH-1:0] measured,
   input  logic [DATA_WIDTH-1:0] mask,
   output logic                  mismatch
);

   // A mask bit of 1 means that bit takes part in the compare.
   assign mismatch = |((expected ^ measured) & mask);

endmodule

// File: rtl/test_scoreboard.sv
// Test scoreboard: counts per-channel compares and mismatches while a test
// runs, then after a drain period issues a registered PASS/FAIL verdict.
// cmp_valid is a per-channel strobe with no back-pressure: every valid bit
// seen in RUN is consumed in that cycle and reflected one clock later.
module test_scoreboard
   import test_scoreboard_pkg::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int NUM_CHANNELS    = 4,
   parameter int NUMBER_OF_TESTS = 0,
   parameter int COUNT_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES  = 50000000,
   parameter int DRAIN_CYCLES    = 200,
   parameter int STOP_ON_FAIL    = 0
) (
   input  logic                               wb_clk,
   input  logic                               wb_rst_n,
   input  logic                               start,
   input  logic                               done,
   input  logic [NUM_CHANNELS-1:0]            cmp_valid,
   input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] cmp_expected,
   input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] cmp_measured,
   input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] cmp_mask,
   output logic [COUNT_WIDTH-1:0]             test_count,
   output logic [COUNT_WIDTH-1:0]             fail_count,
   output logic [CHAN_W-1:0]                  first_fail_chan,
   output logic [COUNT_WIDTH-1:0]             first_fail_index,
   output logic [1:0]                         state,
   output logic [1:0]                         fail_cause,
   output logic                               test_passed,
   output logic                               test_failed
);

   localparam int SW = COUNT_WIDTH + 1;

   sb_state_t                 state_q;
   fail_cause_t               cause_q;
   logic                      done_seen;
   logic [31:0]               drain_cnt;
   logic [31:0]               wd_cnt;

   logic [NUM_CHANNELS-1:0]   lane_mismatch;
   logic [MAX_CHANNELS-1:0]   valid_vec;
   logic [MAX_CHANNELS-1:0]   fail_vec;
   logic [4:0]                valid_pop;
   logic [4:0]                fail_pop;
   logic [CHAN_W-1:0]         first_chan;
   logic                      any_fail;
   logic [SW-1:0]             tc_sum;
   logic [SW-1:0]             fc_sum;
   logic [COUNT_WIDTH-1:0]    tc_next;
   logic [COUNT_WIDTH-1:0]    fc_next;
   logic                      wd_expire;
   logic                      drain_last;

   genvar g;
   generate
      for (g = 0; g < NUM_CHANNELS; g++) begin : g_lane
         test_scoreboard_lane #(
            .DATA_WIDTH (DATA_WIDTH)
         ) u_lane (
            .expected (cmp_expected[g*DATA_WIDTH +: DATA_WIDTH]),
            .measured (cmp_measured[g*DATA_WIDTH +: DATA_WIDTH]),
            .mask     (cmp_mask[g*DATA_WIDTH +: DATA_WIDTH]),
            .mismatch (lane_mismatch[g])
         );
      end
   endgenerate

   // Popcounts, first-fail priority encode and saturating next counts.
   always_comb begin
      valid_vec                     = '0;
      valid_vec[NUM_CHANNELS-1:0]   = cmp_valid;
      fail_vec                      = '0;
      fail_vec[NUM_CHANNELS-1:0]    = cmp_valid & lane_mismatch;
      valid_pop                     = popcount16(valid_vec);
      fail_pop                      = popcount16(fail_vec);
      any_fail                      = |fail_vec;
      first_chan                    = '0;
      for (int i = MAX_CHANNELS - 1; i >= 0; i--) begin
         if (fail_vec[i]) first_chan = CHAN_W'(i);
      end
      tc_sum  = {1'b0, test_count} + SW'(valid_pop);
      fc_sum  = {1'b0, fail_count} + SW'(fail_pop);
      tc_next = tc_sum[COUNT_WIDTH] ? '1 : tc_sum[COUNT_WIDTH-1:0];
      fc_next = fc_sum[COUNT_WIDTH] ? '1 : fc_sum[COUNT_WIDTH-1:0];
   end

   // Watchdog fires on the clock that completes TIMEOUT_CYCLES in RUN;
   // the drain ends on the clock that completes DRAIN_CYCLES after done.
   assign wd_expire  = (TIMEOUT_CYCLES != 0) && (wd_cnt == 32'(TIMEOUT_CYCLES - 1));
   assign drain_last = done_seen && (drain_cnt <= 32'd1);

   // Verdict FSM with counters; start restarts from any state unless the
   // watchdog expires in the same clock.
   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state_q          <= ST_IDLE;
         cause_q          <= CAUSE_NONE;
         test_count       <= '0;
         fail_count       <= '0;
         first_fail_chan  <= '0;
         first_fail_index <= '0;
         done_seen        <= 1'b0;
         drain_cnt        <= '0;
         wd_cnt           <= '0;
         test_passed      <= 1'b0;
         test_failed      <= 1'b0;
      end else if (start && !(state_q == ST_RUN && wd_expire)) begin
         state_q          <= ST_RUN;
         cause_q          <= CAUSE_NONE;
         test_count       <= '0;
         fail_count       <= '0;
         first_fail_chan  <= '0;
         first_fail_index <= '0;
         done_seen        <= 1'b0;
         drain_cnt        <= '0;
         wd_cnt           <= '0;
         test_passed      <= 1'b0;
         test_failed      <= 1'b0;
      end else if (state_q == ST_RUN) begin
         if (|valid_vec) test_count <= tc_next;
         if (any_fail) begin
            fail_count <= fc_next;
            // fail_count never wraps, so zero means nothing captured yet.
            if (fail_count == '0) begin
               first_fail_chan  <= first_chan;
               first_fail_index <= test_count;
            end
         end
         wd_cnt <= wd_cnt + 32'd1;
         if (wd_expire) begin
            state_q     <= ST_FAIL;
            cause_q     <= CAUSE_TIMEOUT;
            test_failed <= 1'b1;
         end else if ((STOP_ON_FAIL != 0) && any_fail) begin
            state_q     <= ST_FAIL;
            cause_q     <= CAUSE_MISMATCH;
            test_failed <= 1'b1;
         end else if (drain_last) begin
            // Verdict includes compares arriving on the final drain clock.
            if (fc_next != '0) begin
               state_q     <= ST_FAIL;
               cause_q     <= CAUSE_MISMATCH;
               test_failed <= 1'b1;
            end else if (tc_next == COUNT_WIDTH'(NUMBER_OF_TESTS)) begin
               state_q     <= ST_PASS;
               test_passed <= 1'b1;
            end else begin
               state_q     <= ST_FAIL;
               cause_q     <= CAUSE_COUNT;
               test_failed <= 1'b1;
            end
         end else if (done_seen) begin
            drain_cnt <= drain_cnt - 32'd1;
         end else if (done) begin
            done_seen <= 1'b1;
            drain_cnt <= 32'(DRAIN_CYCLES);
         end
      end
   end

   assign state      = state_q;
   assign fail_cause = cause_q;

endmodule
